// File: rtl/ex_dm_pipe_reg.sv
// Elastic EX->DM pipeline register with head + skid entry and sync flush.
// Optional EX bypass outputs when EXDM_FWD_EN is defined.
module ex_dm_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     wdata_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [3:0]            ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     wdata_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write
`ifdef EXDM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int EW = 2*DATA_W + REG_ADDR_W + 4;

  logic [EW-1:0] in_ent;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          head_valid_q, head_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          accept, drain;
  logic [3:0]    ctrl_g;

  assign in_ent    = {alu_result_in, wdata_in, rd_in, ctrl_in};
  assign in_ready  = !skid_valid_q;
  assign out_valid = head_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = head_valid_q & out_ready;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case (1'b1)
        !head_valid_q: begin
          if (accept) begin
            head_valid_d = 1'b1;
            head_d       = in_ent;
          end
        end
        head_valid_q & !skid_valid_q: begin
          if (accept && drain) begin
            head_d = in_ent;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_ent;
          end else if (drain) begin
            head_valid_d = 1'b0;
          end
        end
        default: begin
          // skid is younger: it becomes head when the old head drains
          if (drain) begin
            head_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign mem_addr  = head_q[EW-1 -: DATA_W];
  assign wdata_out = head_q[EW-DATA_W-1 -: DATA_W];
  assign rd_out    = head_q[4 +: REG_ADDR_W];
  assign ctrl_g    = head_q[3:0] & {4{head_valid_q}};

  assign mem_read   = ctrl_g[3];
  assign mem_write  = ctrl_g[2];
  assign mem_to_reg = ctrl_g[1];
  assign reg_write  = ctrl_g[0];

`ifdef EXDM_FWD_EN
  assign fwd_valid = ctrl_g[0] & !ctrl_g[1] & (rd_out != '0);
  assign fwd_rd    = fwd_valid ? rd_out : '0;
  assign fwd_data  = fwd_valid ? mem_addr : '0;
`endif

endmodule

// File: tb/tb_ex_dm_pipe_reg.sv
// Directed bench for ex_dm_pipe_reg: reset, stream, back-pressure,
// flush, bubble gating and (with EXDM_FWD_EN) forwarding.
module tb_ex_dm_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] alu_result_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic [3:0]  ctrl_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mem_addr;
  logic [31:0] wdata_out;
  logic [4:0]  rd_out;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
`ifdef EXDM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_dm_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .alu_result_in (alu_result_in),
    .wdata_in      (wdata_in),
    .rd_in         (rd_in),
    .ctrl_in       (ctrl_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .mem_addr      (mem_addr),
    .wdata_out     (wdata_out),
    .rd_out        (rd_out),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write)
`ifdef EXDM_FWD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] r,
                       input logic [3:0] c);
    in_valid      = v;
    alu_result_in = a;
    wdata_in      = w;
    rd_in         = r;
    ctrl_in       = c;
  endtask

  function automatic logic [3:0] ctrl_out();
    return {mem_read, mem_write, mem_to_reg, reg_write};
  endfunction

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h55, 32'h66, 5'd3, 4'b1111);

    // 1 reset
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", ctrl_out(), 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b1;
    drive(1'b1, 32'h55, 32'h66, 5'd3, 4'b0001);
    step();
    chk("r1_valid", out_valid, 1);
    chk("r1_addr", mem_addr, 32'h55);
    chk("r1_wdata", wdata_out, 32'h66);
    chk("r1_rd", rd_out, 3);
    chk("r1_ctrl", ctrl_out(), 4'b0001);
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("r1_drained", out_valid, 0);

    // 2 stream
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 4*i, 32'hA000 + i, 5'(i + 1), 4'b1001);
      step();
      chk("st_valid", out_valid, 1);
      chk("st_addr", mem_addr, 32'h100 + 4*i);
      chk("st_rd", rd_out, 5'(i + 1));
      chk("st_in_ready", in_ready, 1);
    end
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("st_end", out_valid, 0);

    // 3 back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 32'h1, 5'd1, 4'b0001);
    step();
    chk("bp_a_head", mem_addr, 32'hA0);
    chk("bp_rdy1", in_ready, 1);
    drive(1'b1, 32'hB0, 32'h2, 5'd2, 4'b0001);
    step();
    chk("bp_a_hold", mem_addr, 32'hA0);
    chk("bp_full", in_ready, 0);
    drive(1'b1, 32'hC0, 32'h3, 5'd3, 4'b0001);
    step();
    chk("bp_a_still", mem_addr, 32'hA0);
    chk("bp_full2", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_b_head", mem_addr, 32'hB0);
    chk("bp_b_wdata", wdata_out, 32'h2);
    chk("bp_rdy2", in_ready, 1);
    step();
    chk("bp_c_head", mem_addr, 32'hC0);
    chk("bp_c_valid", out_valid, 1);
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("bp_empty", out_valid, 0);

    // 4 flush while full
    out_ready = 1'b0;
    drive(1'b1, 32'hD0, 32'h4, 5'd4, 4'b1011);
    step();
    drive(1'b1, 32'hE0, 32'h5, 5'd5, 4'b1011);
    step();
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'hF0, 32'h6, 5'd6, 4'b1011);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_ctrl", ctrl_out(), 0);
    flush = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("fl_absent", out_valid, 0);

    // 5 bubble
    drive(1'b1, 32'h200, 32'h77, 5'd0, 4'b0100);
    step();
    chk("bb_wr", mem_write, 1);
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("bb_stall_wr", mem_write, 1);
    out_ready = 1'b1;
    step();
    chk("bb_drop_wr", mem_write, 0);
    chk("bb_valid", out_valid, 0);

`ifdef EXDM_FWD_EN
    // 6 forwarding
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 32'h0, 5'd7, 4'b0001);
    step();
    chk("fw_valid", fwd_valid, 1);
    chk("fw_rd", fwd_rd, 7);
    chk("fw_data", fwd_data, 32'hDEAD);
    out_ready = 1'b1;
    drive(1'b1, 32'hBEEF, 32'h0, 5'd0, 4'b0001);
    step();
    chk("fw_rd0_valid", fwd_valid, 0);
    chk("fw_rd0_data", fwd_data, 0);
    drive(1'b1, 32'hCAFE, 32'h0, 5'd5, 4'b1011);
    step();
    chk("fw_m2r_valid", fwd_valid, 0);
    chk("fw_m2r_rd", fwd_rd, 0);
    drive(1'b0, 0, 0, 0, 0);
    step();
    chk("fw_empty", fwd_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
